// File: rtl/ac_alu_if.sv
// Handshake and datapath bundle between the ALU feeder and the sequencer that drives it.
// Master issues opcodes and supplies operands; slave (ac_alu) returns the accumulator controls.
interface ac_alu_if;
  localparam int unsigned W = 16;

  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] acout;
  logic [W-1:0] dr;
  logic [7:0]   inpr;
  logic [W-1:0] acin;
  logic         acld;
  logic         acclr;
  logic         e;
  logic         busy;
  logic         done;

  modport master (
    output start, opcode, acout, dr, inpr,
    input  acin, acld, acclr, e, busy, done
  );

  modport slave (
    input  start, opcode, acout, dr, inpr,
    output acin, acld, acclr, e, busy, done
  );
endinterface

// File: rtl/ac_alu.sv
// Accumulator feeder: computes the next AC value, owns the E flip-flop and strobes acld/acclr for one cycle.
// Optional 16-iteration shift-add multiply on opcode 12 when AC_ALU_MUL_EN is defined.
module ac_alu (
  input logic     clk,
  input logic     rst,
  ac_alu_if.slave bus
);
  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_LDA = 4'd3;
  localparam logic [3:0] OP_CLA = 4'd4;
  localparam logic [3:0] OP_CMA = 4'd5;
  localparam logic [3:0] OP_CIR = 4'd6;
  localparam logic [3:0] OP_CIL = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_CLE = 4'd9;
  localparam logic [3:0] OP_CME = 4'd10;
  localparam logic [3:0] OP_INP = 4'd11;
`ifdef AC_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_EXEC = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd2} state_e;
`endif

  state_e       state_q, state_d;
  logic [W-1:0] acin_q,  acin_d;
  logic         e_q,     e_d;
  logic         acld_q,  acld_d;
  logic         acclr_q, acclr_d;
  logic         done_q,  done_d;
  logic         busy_q,  busy_d;
  logic [W:0]   add_sum;

`ifdef AC_ALU_MUL_EN
  logic [2*W-1:0]   mcand_q,  mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   prod_q,   prod_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2*W-1:0]   prod_sum;
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    acin_d   = acin_q;
    e_d      = e_q;
    acld_d   = 1'b0;
    acclr_d  = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    add_sum  = {1'b0, bus.acout} + {1'b0, bus.dr};
`ifdef AC_ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
`ifdef AC_ALU_MUL_EN
          if (bus.opcode == OP_MUL) begin
            state_d  = S_MUL;
            busy_d   = 1'b1;
            mcand_d  = {{W{1'b0}}, bus.acout};
            mplier_d = bus.dr;
            prod_d   = '0;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d = S_EXEC;
            busy_d  = 1'b1;
            done_d  = 1'b1;
            case (bus.opcode)
              OP_AND: begin acin_d = bus.acout & bus.dr; acld_d = 1'b1; end
              OP_ADD: begin acin_d = add_sum[W-1:0]; e_d = add_sum[W]; acld_d = 1'b1; end
              OP_LDA: begin acin_d = bus.dr; acld_d = 1'b1; end
              OP_CLA: begin acin_d = '0; acclr_d = 1'b1; end
              OP_CMA: begin acin_d = ~bus.acout; acld_d = 1'b1; end
              OP_CIR: begin
                acin_d = {e_q, bus.acout[W-1:1]};
                e_d    = bus.acout[0];
                acld_d = 1'b1;
              end
              OP_CIL: begin
                acin_d = {bus.acout[W-2:0], e_q};
                e_d    = bus.acout[W-1];
                acld_d = 1'b1;
              end
              OP_INC: begin acin_d = bus.acout + W'(1); acld_d = 1'b1; end
              OP_CLE: e_d = 1'b0;
              OP_CME: e_d = ~e_q;
              OP_INP: begin acin_d = {bus.acout[W-1:8], bus.inpr}; acld_d = 1'b1; end
              default: ;
            endcase
          end
        end
      end
`ifdef AC_ALU_MUL_EN
      // One multiplier bit per cycle; the result lands on the last iteration edge
      S_MUL: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = S_EXEC;
          done_d  = 1'b1;
          acld_d  = 1'b1;
          acin_d  = prod_sum[W-1:0];
          e_d     = |prod_sum[2*W-1:W];
        end
      end
`endif
      S_EXEC: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acin_q   <= '0;
      e_q      <= 1'b0;
      acld_q   <= 1'b0;
      acclr_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef AC_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acin_q   <= acin_d;
      e_q      <= e_d;
      acld_q   <= acld_d;
      acclr_q  <= acclr_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef AC_ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.acin  = acin_q;
  assign bus.acld  = acld_q;
  assign bus.acclr = acclr_q;
  assign bus.e     = e_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
